// File: rtl/redux_v_pkg.sv
// Shared definitions for the Redux-V core.
//   ADDR_W, INSTR_W : PC and instruction widths
//   RESET_PC        : PC value loaded on reset
//   fetch_state_e   : fetch sequencer encoding (2'd3 is illegal and recovers to S_IDLE)
package redux_v_pkg;

  localparam int            ADDR_W   = 8;
  localparam int            INSTR_W  = 8;
  localparam logic [7:0]    RESET_PC = 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the architectural PC and sequences instruction fetch.
// It issues one request per instruction, holds the fetched word for decode
// under a valid/ready handshake, and loads next_pc's result only on accept.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   halt         : stop issuing fetches once the current instruction retires
//   next_pc_in   : next PC from the external next_pc block
//   cur_pc       : current PC register (feeds next_pc curPC)
//   imem_req     : request to instruction memory
//   imem_addr    : request address (always cur_pc)
//   imem_ack     : memory returns imem_data this cycle
//   imem_data    : instruction word from memory
//   instr        : registered instruction for decode
//   instr_valid  : instr holds a fetched, unaccepted instruction
//   instr_ready  : decode accepts instr this cycle
//   retired      : count of accepted instructions (wraps)
module fetch_unit
  import redux_v_pkg::fetch_state_e, redux_v_pkg::S_IDLE,
         redux_v_pkg::S_REQ, redux_v_pkg::S_VALID;
#(
  parameter int                ADDR_W   = redux_v_pkg::ADDR_W,
  parameter int                INSTR_W  = redux_v_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = redux_v_pkg::RESET_PC,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic [ADDR_W-1:0]  next_pc_in,
  output logic [ADDR_W-1:0]  cur_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_e state;

  // cur_pc only moves on accept, so it is stable for the whole request.
  assign imem_addr = cur_pc;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, matching the hardware it models.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_pc      <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A stale ack here is ignored: no request is outstanding.
          if (!halt) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          // halt is deliberately ignored; an issued fetch always completes.
          if (imem_ack) begin
            instr       <= imem_data;
            state       <= S_VALID;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            cur_pc      <= next_pc_in;
            retired     <= retired + 1'b1;
            instr_valid <= 1'b0;
            if (halt) begin
              state <= S_IDLE;
            end else begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          end
        end
        default: begin
          // Illegal encoding: drop back to a quiet idle.
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of per-cycle vectors
// (inputs applied before an edge, expected outputs after it) plus
// hand-written reset-in-flight sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [7:0]  next_pc_in;
  logic [7:0]  cur_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_data;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] retired;

  int passed = 0;
  int total  = 0;

  // Memory returns data equal to the address.
  assign imem_data = imem_addr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .next_pc_in  (next_pc_in),
    .cur_pc      (cur_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .retired     (retired)
  );

  typedef struct {
    logic        h, a, r;
    logic [7:0]  npc;
    logic        req, valid;
    logic [7:0]  instr, pc;
    logic [15:0] ret;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic h, a, r, input logic [7:0] npc,
                              input logic req, valid, input logic [7:0] ins, pc,
                              input logic [15:0] ret);
    vec_t v;
    v.h = h; v.a = a; v.r = r; v.npc = npc;
    v.req = req; v.valid = valid; v.instr = ins; v.pc = pc; v.ret = ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic check_all(input string tag, input logic req, valid,
                           input logic [7:0] ins, pc, input logic [15:0] ret);
    check({tag, " imem_req"},    32'(imem_req),    32'(req));
    check({tag, " instr_valid"}, 32'(instr_valid), 32'(valid));
    check({tag, " instr"},       32'(instr),       32'(ins));
    check({tag, " cur_pc"},      32'(cur_pc),      32'(pc));
    check({tag, " retired"},     32'(retired),     32'(ret));
    if (req) check({tag, " imem_addr"}, 32'(imem_addr), 32'(pc));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            h     a     r     npc    req   vld   instr  pc    ret
    // Sequential fetch 0,1,2 (then 3)
    vecs[0]  = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 8'd0,   8'd0,   16'd0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd0,   8'd0,   16'd0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b1, 8'd1,  1'b1, 1'b0, 8'd0,   8'd1,   16'd1);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd1,   8'd1,   16'd1);
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 8'd2,  1'b1, 1'b0, 8'd1,   8'd2,   16'd2);
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd2,   8'd2,   16'd2);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 8'd3,  1'b1, 1'b0, 8'd2,   8'd3,   16'd3);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd3,   8'd3,   16'd3);
    // Jumps: 120 -> 126 -> 55
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 8'd120, 1'b1, 1'b0, 8'd3,  8'd120, 16'd4);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd120, 8'd120, 16'd4);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 8'd126, 1'b1, 1'b0, 8'd120, 8'd126, 16'd5);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd126, 8'd126, 16'd5);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 8'd55, 1'b1, 1'b0, 8'd126, 8'd55,  16'd6);
    vecs[13] = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd55,  8'd55,  16'd6);
    // Wrap: 0 -> 252, 255 -> 0
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 8'd0,  1'b1, 1'b0, 8'd55,  8'd0,   16'd7);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd0,   8'd0,   16'd7);
    vecs[16] = mk(1'b0, 1'b1, 1'b1, 8'd252, 1'b1, 1'b0, 8'd0,  8'd252, 16'd8);
    vecs[17] = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd252, 8'd252, 16'd8);
    vecs[18] = mk(1'b0, 1'b1, 1'b1, 8'd255, 1'b1, 1'b0, 8'd252, 8'd255, 16'd9);
    vecs[19] = mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 8'd255, 8'd255, 16'd9);
    vecs[20] = mk(1'b0, 1'b1, 1'b1, 8'd0,  1'b1, 1'b0, 8'd255, 8'd0,   16'd10);
    // Memory wait 3 cycles (halt high must not cancel the fetch)
    vecs[21] = mk(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 8'd255, 8'd0,   16'd10);
    vecs[22] = mk(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 8'd255, 8'd0,   16'd10);
    vecs[23] = mk(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 8'd255, 8'd0,   16'd10);
    vecs[24] = mk(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 8'd0,   8'd0,   16'd10);
    // Decode stall 4 cycles, then accept with halt high
    vecs[25] = mk(1'b1, 1'b0, 1'b0, 8'd77, 1'b0, 1'b1, 8'd0,   8'd0,   16'd10);
    vecs[26] = mk(1'b1, 1'b0, 1'b0, 8'd77, 1'b0, 1'b1, 8'd0,   8'd0,   16'd10);
    vecs[27] = mk(1'b1, 1'b0, 1'b0, 8'd77, 1'b0, 1'b1, 8'd0,   8'd0,   16'd10);
    vecs[28] = mk(1'b1, 1'b0, 1'b0, 8'd77, 1'b0, 1'b1, 8'd0,   8'd0,   16'd10);
    vecs[29] = mk(1'b1, 1'b0, 1'b1, 8'd8,  1'b0, 1'b0, 8'd0,   8'd8,   16'd11);
    // Halted idle: stale acks ignored, then release halt
    vecs[30] = mk(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 8'd0,   8'd8,   16'd11);
    vecs[31] = mk(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 8'd0,   8'd8,   16'd11);
    vecs[32] = mk(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 8'd0,   8'd8,   16'd11);
    vecs[33] = mk(1'b0, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 8'd8,   8'd8,   16'd11);
    vecs[34] = mk(1'b0, 1'b1, 1'b1, 8'd40, 1'b1, 1'b0, 8'd8,   8'd40,  16'd12);
    vecs[35] = mk(1'b0, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 8'd40,  8'd40,  16'd12);

    // Reset with stimulus that would otherwise move the design.
    rst = 1'b1; halt = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1; next_pc_in = 8'h33;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      halt        = vecs[i].h;
      imem_ack    = vecs[i].a;
      instr_ready = vecs[i].r;
      next_pc_in  = vecs[i].npc;
      tick();
      check_all($sformatf("row%0d", i), vecs[i].req, vecs[i].valid,
                vecs[i].instr, vecs[i].pc, vecs[i].ret);
    end

    // Reset in S_VALID with cur_pc=40.
    rst = 1'b1; imem_ack = 1'b1; instr_ready = 1'b0; next_pc_in = 8'hEE;
    tick();
    check_all("rst_valid", 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    // Stale ack in S_IDLE is ignored; first request at address 0.
    rst = 1'b0;
    tick();
    check_all("post_rst_req", 1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    next_pc_in = 8'd9;
    tick();
    check_all("post_rst_valid", 1'b0, 1'b1, 8'd0, 8'd0, 16'd0);
    instr_ready = 1'b1;
    tick();
    check_all("accept_to_9", 1'b1, 1'b0, 8'd0, 8'd9, 16'd1);
    // Reset in S_REQ with ack present: the fetch of address 9 is abandoned.
    rst = 1'b1; next_pc_in = 8'hEE;
    tick();
    check_all("rst_req", 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Owns the architectural program counter and sequences instruction fetch for the Redux-V core. It presents the current PC to next_pc as curPC and drives the instruction-memory request handshake. It hands fetched instructions to decode through a valid/ready handshake. It loads next_pc's pc output back into the PC register only when decode accepts the instruction.

Parameters:
ADDR_W, 8, width of PC and instruction-memory address
INSTR_W, 8, width of an instruction word
RESET_PC, 8'd0, PC value loaded on reset
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
halt  input  1  when high, stop issuing new fetches after the current instruction retires
next_pc_in  input  ADDR_W  next PC from next_pc; combinational function of cur_pc and decode fields
cur_pc  output  ADDR_W  current PC register; drives next_pc curPC
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address; equals cur_pc while imem_req is high
imem_ack  input  1  memory has imem_data valid this cycle
imem_data  input  INSTR_W  instruction word from memory
instr  output  INSTR_W  registered instruction presented to decode
instr_valid  output  1  instr holds a fetched, unaccepted instruction
instr_ready  input  1  decode accepts instr this cycle
retired  output  CNT_W  count of instructions accepted by decode

Behaviour:
- Reset (rst high at a clock edge, any state):
  - cur_pc=RESET_PC, state=S_IDLE, instr=0, instr_valid=0, imem_req=0, retired=0.
  - Reset overrides every other input that cycle.
- States:
  - S_IDLE:
    - imem_req=0, instr_valid=0.
    - If halt=0, go to S_REQ; otherwise stay.
    - imem_ack is ignored in this state, including a stale ack after a reset.
  - S_REQ:
    - imem_req=1, imem_addr=cur_pc.
    - On imem_ack=1: latch imem_data into instr and go to S_VALID. An ack in the first S_REQ cycle is legal, so zero-wait memory works.
    - On imem_ack=0: stay, holding imem_addr stable.
    - halt has no effect here; an issued fetch always completes.
  - S_VALID:
    - instr_valid=1, imem_req=0; instr is held stable.
    - On instr_ready=1 (accept):
      - cur_pc <= next_pc_in.
      - retired <= retired+1, wrapping modulo 2^CNT_W.
      - Next state is S_IDLE if halt=1, else S_REQ.
    - On instr_ready=0: stay, with cur_pc and instr unchanged (decode stall).
- Latency:
  - From rst deassertion with halt=0 and combinational ack: S_IDLE in cycle 0, S_REQ in cycle 1, instr_valid=1 in cycle 2.
  - Steady-state throughput is one instruction per 2 cycles (REQ, VALID).
- cur_pc changes only at reset or on accept. next_pc_in must therefore be stable in the accept cycle; next_pc depends on cur_pc, which is constant throughout S_VALID.
- Width rules:
  - The PC wraps modulo 2^ADDR_W. next_pc supplies the wrapped value (e.g. 0 + (-4) = 252); fetch_unit performs no arithmetic on the PC.
  - No overflow flag is raised.
- Simultaneous events:
  - halt rising in the same cycle as accept: the PC still updates and the next state is S_IDLE.
  - halt falling while in S_IDLE: the first request is issued the next cycle at the updated cur_pc.
- Reset mid-operation, in S_REQ or S_VALID: the pending fetch or instruction is discarded and instr_valid drops on the next cycle. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package redux_v_pkg holds:
  - ADDR_W, INSTR_W and RESET_PC constants.
  - The fetch state encoding (S_IDLE=2'd0, S_REQ=2'd1, S_VALID=2'd2; 2'd3 is illegal and recovers to S_IDLE).
- Single module with no sub-module.
- next_pc stays a separate instance at the core level, wired cur_pc→curPC and pc→next_pc_in.

Test Plan:
1. Reset with halt=0, imem_ack tied high, memory returning data=addr, instr_ready=1, next_pc wired in sequential mode → instr sequence 0,1,2 with instr_valid every 2nd cycle; retired=3 after the third accept.
2. cur_pc=120, next_pc_in forced to 126 (jump, imm=6) on accept → next imem_addr=126. Then next_pc_in=55 (branch to Rb) → imem_addr=55.
3. cur_pc=0, next_pc_in=252 (imm=-4) → imem_addr=252. Then sequential mode from 255 → the following fetch is at 0 (wrap).
4. imem_ack held low 3 cycles in S_REQ → imem_req and imem_addr stable for 3 cycles, instr_valid=0. On the ack cycle → instr_valid=1 the next cycle.
5. instr_ready low 4 cycles while instr_valid=1 → instr, cur_pc and retired unchanged, imem_req=0. halt=1 asserted at the accept → S_IDLE, no further imem_req until halt=0.
6. rst pulsed in S_VALID with cur_pc=40 → next cycle cur_pc=0, instr_valid=0, retired=0. A stale imem_ack in S_IDLE is ignored, and the first new request is at address 0.
